// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives combinational imem, and registers
// the returned word into an IF/ID register with valid/ready towards decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        load;
  logic [31:0] pc_plus4;

  assign load     = ~id_valid_q | id_ready;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    fetch_fault_d = fetch_fault_q;
    fault_pc_d    = fault_pc_q;
    // A redirect overrides stall and load in every state.
    if (redirect_valid) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d          = redirect_pc;
        state_d       = RUN;
        fetch_fault_d = 1'b0;
      end else begin
        state_d       = FAULT;
        fetch_fault_d = 1'b1;
        fault_pc_d    = redirect_pc;
      end
    end else begin
      case (state_q)
        BOOT: state_d = RUN;  // imem output may still be reset-gated; skip it
        RUN: begin
          if (load) begin
            id_valid_d    = 1'b1;
            id_instr_d    = imem_rdata;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            pc_d          = pc_plus4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      fetch_fault_q <= 1'b0;
      fault_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      fetch_fault_q <= fetch_fault_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign fetch_fault = fetch_fault_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory word i returns 32'h100+i.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b1;
  logic        id_valid, fetch_fault;
  logic [31:0] id_instr, id_pc, id_pc_plus4, fault_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;
  assign imem_rdata = 32'h100 + {2'b00, imem_addr[31:2]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string nm, input logic v, input logic [31:0] ins, input logic [31:0] pc);
    n_checks++;
    if (id_valid !== v || id_instr !== ins || id_pc !== pc || (v && id_pc_plus4 !== pc + 32'd4)) begin
      n_fail++;
      $display("FAIL %s: got v=%b instr=%h pc=%h pc4=%h, want v=%b instr=%h pc=%h pc4=%h",
               nm, id_valid, id_instr, id_pc, id_pc_plus4, v, ins, pc, pc + 32'd4);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 0 || id_pc_plus4 !== 0 ||
        fetch_fault !== 1'b0 || fault_pc !== 0 || imem_addr !== 0) begin
      n_fail++;
      $display("FAIL reset_values: v=%b instr=%h pc=%h pc4=%h ff=%b fpc=%h addr=%h",
               id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault, fault_pc, imem_addr);
    end
    tick();
    rst = 1'b0;
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_c0: v=%b want 0", id_valid); end
    tick();
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_c1: v=%b want 0", id_valid); end
    tick(); chk_id("first_fetch", 1'b1, 32'h100, 32'h0);
    tick(); chk_id("second_fetch", 1'b1, 32'h101, 32'h4);
    tick(); chk_id("third_fetch", 1'b1, 32'h102, 32'h8);
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_id("stall_hold", 1'b1, 32'h102, 32'h8);
      n_checks++;
      if (imem_addr !== 32'd12) begin n_fail++; $display("FAIL stall_addr: got %h want 0000000c", imem_addr); end
    end
    id_ready = 1'b1;
    tick(); chk_id("stall_release_12", 1'b1, 32'h103, 32'd12);
    tick(); chk_id("stall_release_16", 1'b1, 32'h104, 32'd16);
  endtask

  task automatic test_redirect();
    id_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk_id("redir_stall_bubble", 1'b0, NOP, 32'd16);
    n_checks++;
    if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr: got %h want 00000040", imem_addr); end
    tick(); chk_id("redir_stall_target", 1'b1, 32'h110, 32'h40);
    id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    chk_id("redir_bubble", 1'b0, NOP, 32'h40);
    tick(); chk_id("redir_target", 1'b1, 32'h108, 32'h20);
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h42 || id_valid !== 1'b0 || imem_addr !== 32'h24) begin
      n_fail++;
      $display("FAIL misalign_1: ff=%b fpc=%h v=%b addr=%h want 1 00000042 0 00000024",
               fetch_fault, fault_pc, id_valid, imem_addr);
    end
    tick();
    n_checks++;
    if (fetch_fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'h24 || id_instr !== NOP) begin
      n_fail++;
      $display("FAIL fault_hold: ff=%b v=%b addr=%h instr=%h want 1 0 00000024 %h",
               fetch_fault, id_valid, imem_addr, id_instr, NOP);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h47;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h47) begin
      n_fail++; $display("FAIL misalign_2: ff=%b fpc=%h want 1 00000047", fetch_fault, fault_pc);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 32'h80) begin
      n_fail++; $display("FAIL fault_exit: ff=%b v=%b addr=%h want 0 0 00000080", fetch_fault, id_valid, imem_addr);
    end
    tick(); chk_id("fault_exit_target", 1'b1, 32'h120, 32'h80);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk_id("wrap_bubble", 1'b0, NOP, 32'h80);
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'd0 ||
        id_instr !== 32'h4000_00FF || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_top: v=%b pc=%h pc4=%h instr=%h addr=%h want 1 fffffffc 00000000 400000ff 00000000",
               id_valid, id_pc, id_pc_plus4, id_instr, imem_addr);
    end
    tick(); chk_id("wrap_zero", 1'b1, 32'h100, 32'h0);
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'd0 || fetch_fault !== 1'b0 || id_instr !== NOP || id_pc !== 0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b addr=%h ff=%b instr=%h pc=%h", id_valid, imem_addr, fetch_fault, id_instr, id_pc);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reboot_c1: v=%b want 0", id_valid); end
    tick(); chk_id("reboot_first", 1'b1, 32'h100, 32'h0);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
